// File: rtl/pn_code_gen_if.sv
// Control/status bundle between the FSK framing logic and the PN code source.
// The framing logic drives the master side; the code generator is the slave.
interface pn_code_gen_if #(
  parameter int W = 8
) ();
  logic         enable;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] seed_in;
  logic         code;
  logic         bit_stb;
  logic         word_stb;
  logic [15:0]  word_cnt;

  modport master (
    output enable, mode, load, seed_in,
    input  code, bit_stb, word_stb, word_cnt
  );

  modport slave (
    input  enable, mode, load, seed_in,
    output code, bit_stb, word_stb, word_cnt
  );
endinterface

// File: rtl/pn_code_gen.sv
// Serial code source for the 2FSK modulator: one bit per DIV clocks from LFSR, rotated seed, toggle or zero.
// First bit appears DIV edges after restart; no backpressure, enable low holds the bit timing in restart.
module pn_code_gen #(
  parameter int          W    = 8,
  parameter logic [31:0] TAPS = 32'h8E,
  parameter logic [31:0] SEED = 32'hAA,
  parameter int          DIV  = 1
) (
  input logic          clk,
  input logic          rst_n,
  pn_code_gen_if.slave bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(W);

  localparam logic [W-1:0]     TAP_MASK = TAPS[W-1:0];
  localparam logic [W-1:0]     SEED_VAL = SEED[W-1:0];
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  localparam logic [1:0] MODE_PN  = 2'd0;
  localparam logic [1:0] MODE_ROT = 2'd1;
  localparam logic [1:0] MODE_ALT = 2'd2;

  logic [W-1:0]     sr_q, sr_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             code_q, code_d;
  logic             bit_stb_q, bit_stb_d;
  logic             word_stb_q, word_stb_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             fb;

  assign fb = ^(sr_q & TAP_MASK);

  always_comb begin
    sr_d       = sr_q;
    div_cnt_d  = div_cnt_q;
    bit_idx_d  = bit_idx_q;
    code_d     = code_q;
    bit_stb_d  = 1'b0;
    word_stb_d = 1'b0;
    word_cnt_d = word_cnt_q;

    if (bus.load) begin
      // A zero seed would lock the LFSR, so fall back to the reset state.
      sr_d      = (bus.seed_in == '0) ? SEED_VAL : bus.seed_in;
      div_cnt_d = '0;
      bit_idx_d = '0;
    end else if (!bus.enable) begin
      div_cnt_d = '0;
      bit_idx_d = '0;
    end else if (div_cnt_q != DIV_LAST) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_d = '0;
      bit_stb_d = 1'b1;
      case (bus.mode)
        MODE_PN: begin
          code_d = sr_q[W-1];
          sr_d   = {sr_q[W-2:0], fb};
        end
        MODE_ROT: begin
          code_d = sr_q[W-1];
          sr_d   = {sr_q[W-2:0], sr_q[W-1]};
        end
        MODE_ALT: code_d = ~code_q;
        default:  code_d = 1'b0;
      endcase
      if (bit_idx_q == IDX_LAST) begin
        bit_idx_d  = '0;
        word_stb_d = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
      end else begin
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= SEED_VAL;
      div_cnt_q  <= '0;
      bit_idx_q  <= '0;
      code_q     <= 1'b0;
      bit_stb_q  <= 1'b0;
      word_stb_q <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      sr_q       <= sr_d;
      div_cnt_q  <= div_cnt_d;
      bit_idx_q  <= bit_idx_d;
      code_q     <= code_d;
      bit_stb_q  <= bit_stb_d;
      word_stb_q <= word_stb_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.code     = code_q;
  assign bus.bit_stb  = bit_stb_q;
  assign bus.word_stb = word_stb_q;
  assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_pn_code_gen.sv
// Directed bench: a DIV=1 instance for PN/load/gap/mode tests and a DIV=4 instance for bit timing.
module tb_pn_code_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pn_code_gen_if #(.W(8)) b1 ();
  pn_code_gen_if #(.W(8)) b4 ();

  pn_code_gen #(.W(8), .TAPS(32'h8E), .SEED(32'hAA), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  pn_code_gen #(.W(8), .TAPS(32'h8E), .SEED(32'hAA), .DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  // Expected first 16 PN bits from seed 8'hAA, MSB first.
  logic [15:0] pn_seq;
  logic [7:0]  pat;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.enable = 1'b0; b1.mode = 2'd0; b1.load = 1'b0; b1.seed_in = 8'h00;
    b4.enable = 1'b0; b4.mode = 2'd0; b4.load = 1'b0; b4.seed_in = 8'h00;
    tick();
    tick();
    tests++; if (b1.code !== 1'b0) begin fails++; $display("FAIL reset_code: got %b expected 0", b1.code); end
    tests++; if (b1.bit_stb !== 1'b0) begin fails++; $display("FAIL reset_bit_stb: got %b expected 0", b1.bit_stb); end
    tests++; if (b1.word_stb !== 1'b0) begin fails++; $display("FAIL reset_word_stb: got %b expected 0", b1.word_stb); end
    tests++; if (b1.word_cnt !== 16'd0) begin fails++; $display("FAIL reset_word_cnt: got %0d expected 0", b1.word_cnt); end
    tests++; if (b4.code !== 1'b0) begin fails++; $display("FAIL reset_code4: got %b expected 0", b4.code); end
    rst_n = 1'b1;
  endtask

  task automatic test_pn_defaults();
    b1.mode = 2'd0;
    b1.enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests++; if (b1.code !== pn_seq[15-i]) begin fails++; $display("FAIL pn_code[%0d]: got %b expected %b", i, b1.code, pn_seq[15-i]); end
      tests++; if (b1.bit_stb !== 1'b1) begin fails++; $display("FAIL pn_bit_stb[%0d]: got %b expected 1", i, b1.bit_stb); end
      tests++; if (b1.word_stb !== (i == 7 || i == 15)) begin fails++; $display("FAIL pn_word_stb[%0d]: got %b expected %b", i, b1.word_stb, (i == 7 || i == 15)); end
    end
    tests++; if (b1.word_cnt !== 16'd2) begin fails++; $display("FAIL pn_word_cnt: got %0d expected 2", b1.word_cnt); end
    b1.enable = 1'b0;
    tick();
    tests++; if (b1.bit_stb !== 1'b0) begin fails++; $display("FAIL pn_disable_stb: got %b expected 0", b1.bit_stb); end
  endtask

  task automatic test_reset_mid();
    b1.enable = 1'b1;
    tick();
    tick();
    tests++; if (b1.code !== 1'b1) begin fails++; $display("FAIL mid_bit18: got %b expected 1", b1.code); end
    rst_n = 1'b0;
    #1;
    tests++; if (b1.code !== 1'b0) begin fails++; $display("FAIL mid_rst_code: got %b expected 0", b1.code); end
    tests++; if (b1.bit_stb !== 1'b0) begin fails++; $display("FAIL mid_rst_bit_stb: got %b expected 0", b1.bit_stb); end
    tests++; if (b1.word_cnt !== 16'd0) begin fails++; $display("FAIL mid_rst_word_cnt: got %0d expected 0", b1.word_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (b1.code !== 1'b1) begin fails++; $display("FAIL post_rst_bit1: got %b expected 1", b1.code); end
    tests++; if (b1.bit_stb !== 1'b1) begin fails++; $display("FAIL post_rst_stb: got %b expected 1", b1.bit_stb); end
    tick();
    tests++; if (b1.code !== 1'b0) begin fails++; $display("FAIL post_rst_bit2: got %b expected 0", b1.code); end
    b1.enable = 1'b0;
    tick();
  endtask

  task automatic test_div4_alternate();
    logic exp_code;
    b4.mode = 2'd2;
    b4.enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_code = ((c / 4) % 2) == 1;
      tests++; if (b4.bit_stb !== (c % 4 == 0)) begin fails++; $display("FAIL div4_bit_stb[%0d]: got %b expected %b", c, b4.bit_stb, (c % 4 == 0)); end
      tests++; if (b4.code !== exp_code) begin fails++; $display("FAIL div4_code[%0d]: got %b expected %b", c, b4.code, exp_code); end
      tests++; if (b4.word_stb !== 1'b0) begin fails++; $display("FAIL div4_word_stb[%0d]: got %b expected 0", c, b4.word_stb); end
    end
    b4.enable = 1'b0;
  endtask

  task automatic test_load();
    b1.load = 1'b1; b1.seed_in = 8'h00; b1.enable = 1'b1; b1.mode = 2'd0;
    tick();
    tests++; if (b1.code !== 1'b0) begin fails++; $display("FAIL load_code_hold: got %b expected 0", b1.code); end
    tests++; if (b1.bit_stb !== 1'b0) begin fails++; $display("FAIL load_bit_stb: got %b expected 0", b1.bit_stb); end
    b1.load = 1'b0;
    pat = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++; if (b1.code !== pat[7-i]) begin fails++; $display("FAIL load_zero_code[%0d]: got %b expected %b", i, b1.code, pat[7-i]); end
      tests++; if (b1.word_stb !== (i == 7)) begin fails++; $display("FAIL load_zero_word_stb[%0d]: got %b expected %b", i, b1.word_stb, (i == 7)); end
    end
    tests++; if (b1.word_cnt !== 16'd1) begin fails++; $display("FAIL load_zero_word_cnt: got %0d expected 1", b1.word_cnt); end
    b1.load = 1'b1; b1.seed_in = 8'hF0; b1.mode = 2'd1;
    tick();
    tests++; if (b1.bit_stb !== 1'b0) begin fails++; $display("FAIL load_f0_bit_stb: got %b expected 0", b1.bit_stb); end
    b1.load = 1'b0;
    pat = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests++; if (b1.code !== pat[7-(i%8)]) begin fails++; $display("FAIL rot_code[%0d]: got %b expected %b", i, b1.code, pat[7-(i%8)]); end
      tests++; if (b1.word_stb !== (i % 8 == 7)) begin fails++; $display("FAIL rot_word_stb[%0d]: got %b expected %b", i, b1.word_stb, (i % 8 == 7)); end
    end
    tests++; if (b1.word_cnt !== 16'd3) begin fails++; $display("FAIL rot_word_cnt: got %0d expected 3", b1.word_cnt); end
    b1.enable = 1'b0;
    tick();
  endtask

  task automatic test_enable_gap();
    b1.load = 1'b1; b1.seed_in = 8'hAA; b1.mode = 2'd0; b1.enable = 1'b1;
    tick();
    b1.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (b1.code !== pn_seq[15-i]) begin fails++; $display("FAIL gap_pre_code[%0d]: got %b expected %b", i, b1.code, pn_seq[15-i]); end
    end
    b1.enable = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      tests++; if (b1.bit_stb !== 1'b0) begin fails++; $display("FAIL gap_bit_stb[%0d]: got %b expected 0", g, b1.bit_stb); end
      tests++; if (b1.word_stb !== 1'b0) begin fails++; $display("FAIL gap_word_stb[%0d]: got %b expected 0", g, b1.word_stb); end
      tests++; if (b1.code !== 1'b1) begin fails++; $display("FAIL gap_code_hold[%0d]: got %b expected 1", g, b1.code); end
    end
    b1.enable = 1'b1;
    for (int i = 5; i < 13; i++) begin
      tick();
      tests++; if (b1.code !== pn_seq[15-i]) begin fails++; $display("FAIL gap_post_code[%0d]: got %b expected %b", i, b1.code, pn_seq[15-i]); end
      tests++; if (b1.word_stb !== (i == 12)) begin fails++; $display("FAIL gap_word_stb_post[%0d]: got %b expected %b", i, b1.word_stb, (i == 12)); end
    end
    tests++; if (b1.word_cnt !== 16'd4) begin fails++; $display("FAIL gap_word_cnt: got %0d expected 4", b1.word_cnt); end
  endtask

  task automatic test_mode_switch();
    b1.load = 1'b1; b1.seed_in = 8'hAA; b1.mode = 2'd0; b1.enable = 1'b1;
    tick();
    b1.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (b1.code !== pn_seq[15-i]) begin fails++; $display("FAIL sw_pn_code[%0d]: got %b expected %b", i, b1.code, pn_seq[15-i]); end
    end
    b1.mode = 2'd3;
    for (int i = 3; i < 8; i++) begin
      tick();
      tests++; if (b1.code !== 1'b0) begin fails++; $display("FAIL sw_zero_code[%0d]: got %b expected 0", i, b1.code); end
      tests++; if (b1.bit_stb !== 1'b1) begin fails++; $display("FAIL sw_bit_stb[%0d]: got %b expected 1", i, b1.bit_stb); end
      tests++; if (b1.word_stb !== (i == 7)) begin fails++; $display("FAIL sw_word_stb[%0d]: got %b expected %b", i, b1.word_stb, (i == 7)); end
    end
    // Zero mode left the register untouched, so PN resumes at the fourth bit.
    b1.mode = 2'd0;
    for (int i = 3; i < 5; i++) begin
      tick();
      tests++; if (b1.code !== pn_seq[15-i]) begin fails++; $display("FAIL sw_resume_code[%0d]: got %b expected %b", i, b1.code, pn_seq[15-i]); end
      tests++; if (b1.word_stb !== 1'b0) begin fails++; $display("FAIL sw_resume_word_stb[%0d]: got %b expected 0", i, b1.word_stb); end
    end
    tests++; if (b1.word_cnt !== 16'd5) begin fails++; $display("FAIL sw_word_cnt: got %0d expected 5", b1.word_cnt); end
    b1.enable = 1'b0;
    tick();
  endtask

  initial begin
    pn_seq = 16'b1010_1010_1110_0000;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_pn_defaults();
    test_reset_mid();
    test_div4_alternate();
    test_load();
    test_enable_gap();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pn_code_gen.md
# pn_code_gen

Parametrised serial baseband source for the 2FSK transmitter. It produces a serial code bit stream at a programmable bit rate, one bit per DIV clocks. The bit stream comes from a W-bit Fibonacci LFSR (PN mode), a repeating seed word, an alternating 1/0 pattern or constant zero. It sits ahead of the FSK modulator: `code` selects the tone, and the strobes give the modulator and the framing logic bit and word timing.

## Interface
Parameters:
- `W`, 8: LFSR/word width, 2..32.
- `TAPS`, 8'h8E: feedback mask. Bit k set means state bit k is XORed into feedback. `TAPS[W-1]` must be 1. The default is x^8+x^4+x^3+x^2+1, taps 7, 3, 2, 1.
- `SEED`, 8'hAA: reset and fallback state. It must be nonzero.
- `DIV`, 1: clocks per bit, at least 1.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `enable`, in, 1: run. When low, the bit timing is held in restart.
- `mode`, in, 2: 0 = PN, 1 = rotate seed word, 2 = alternate, 3 = zero.
- `load`, in, 1: synchronous one-cycle state load.
- `seed_in`, in, W: value loaded on `load`.
- `code`, out, 1: registered serial bit.
- `bit_stb`, out, 1: one-cycle pulse in the cycle `code` takes a new bit.
- `word_stb`, out, 1: one-cycle pulse coincident with the `bit_stb` of the W-th bit of a word.
- `word_cnt`, out, 16: completed-word count, wraps 16'hFFFF to 0.

## Operation
Internal state:
- `sr`: W bits.
- `div_cnt`: 0..DIV-1.
- `bit_idx`: 0..W-1.

Reset values (`rst_n` low, asynchronous):
- `sr` = SEED.
- `div_cnt` = 0, `bit_idx` = 0.
- `code` = 0, `bit_stb` = 0, `word_stb` = 0, `word_cnt` = 0.

Per rising edge, first matching rule wins:
1. `load` = 1:
   - `sr` <= `seed_in`, or SEED if `seed_in` == 0.
   - `div_cnt` <= 0, `bit_idx` <= 0.
   - `code` holds; strobes 0; `word_cnt` holds.
   - Load has priority over `enable`.
2. `enable` = 0:
   - `div_cnt` <= 0, `bit_idx` <= 0.
   - `code` holds, `sr` holds, strobes 0.
3. `enable` = 1 and `div_cnt` != DIV-1:
   - `div_cnt` += 1; strobes 0.
4. `enable` = 1 and `div_cnt` == DIV-1 (emission):
   - `div_cnt` <= 0, `bit_stb` <= 1.
   - Mode 0: `code` <= `sr[W-1]`; `sr` <= {`sr[W-2:0]`, fb}, where fb = XOR-reduce(`sr` & TAPS).
   - Mode 1: `code` <= `sr[W-1]`; `sr` <= {`sr[W-2:0]`, `sr[W-1]`}.
   - Mode 2: `code` <= ~`code`; `sr` holds.
   - Mode 3: `code` <= 0; `sr` holds.
   - If `bit_idx` == W-1: `bit_idx` <= 0, `word_stb` <= 1, `word_cnt` += 1. Otherwise `bit_idx` += 1.

Mode and state rules:
- `mode` is sampled only at emission. A change mid-word takes effect on the next bit; counters are not reset.
- PN mode never reaches the all-zero state, because SEED is nonzero and `TAPS[W-1]` = 1 makes the map invertible.
- Bits are emitted MSB first. `sr` bits above W do not exist: all arithmetic is W bits wide and `word_cnt` is 16 bits modular.

## Timing
- Latency: with `enable` held high from a restart, the first bit appears in `code` after DIV rising edges. Later bits follow every DIV edges.
- `bit_stb` and `word_stb` are high for exactly one cycle, the cycle after the emission edge, aligned with the new `code` value.
- DIV = 1: `bit_stb` stays high continuously while enabled.
- Dropping `enable` mid-word discards the partial bit and word timing. After re-enable, the next `word_stb` comes after W further bits; the `sr` content continues from where it stopped.
- Load and enable high together: load wins; emission restarts DIV edges after the first enabled non-load edge.
- Reset mid-operation: all outputs return to reset values immediately. The first post-reset bit appears DIV edges after `rst_n` deasserts with `enable` high.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream → `code`, `bit_stb`, `word_stb` = 0 and `word_cnt` = 0 immediately. After release with `mode` = 0, DIV = 1, the first bit is 1.
- PN defaults (W = 8, TAPS = 8'h8E, SEED = 8'hAA, DIV = 1, `enable` = 1) → first 16 bits are 1010_1010_1110_0000. `word_stb` pulses on bits 8 and 16; `word_cnt` = 2.
- DIV = 4, mode 2 → `bit_stb` every 4th cycle; `code` toggles 1, 0, 1, 0 starting from 0 after reset.
- Load: `seed_in` = 8'h00 with `load` = 1 → state becomes 8'hAA. Then `seed_in` = 8'hF0 in mode 1 → bits 1111_0000 repeat every word.
- Enable gap: drop `enable` after 5 bits for 3 cycles → no strobes during the gap; `word_stb` comes 8 bits after re-enable; the bit sequence continues unbroken.
- Mode switch 0→3 mid-word → `code` = 0 from the next emission, `bit_idx` is not reset, and `word_stb` timing is unchanged.
